// File: rtl/floor_destination.sv
// Elevator front-end: synchronizes the slide switches, picks the next destination
// floor from the synced requests, current floor and direction, and drives the floor readout.
module floor_destination #(
  parameter int NUM_FLOORS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic       direction,
  input  logic [2:0] current,
  output logic [9:0] sw_sync,
  output logic [2:0] sel,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [9:0]            sw_p [SYNC_STAGES];
  logic [2:0]            sel_p2;
  logic [NUM_FLOORS-1:0] req;

  // Nearest request ahead in the travel direction wins; otherwise the nearest one behind.
  // The request at the current floor never qualifies, so with no others we hold position.
  function automatic logic [2:0] pick_dest(input logic [NUM_FLOORS-1:0] r,
                                           input logic [2:0] cur,
                                           input logic dir);
    logic       up_found;
    logic       dn_found;
    logic [2:0] up_sel;
    logic [2:0] dn_sel;
    up_found = 1'b0;
    dn_found = 1'b0;
    up_sel   = cur;
    dn_sel   = cur;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r[i] && (i > int'(cur))) begin
        up_found = 1'b1;
        up_sel   = 3'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r[i] && (i < int'(cur))) begin
        dn_found = 1'b1;
        dn_sel   = 3'(i);
      end
    end
    if (int'(cur) >= NUM_FLOORS)
      pick_dest = cur;
    else if (dir)
      pick_dest = up_found ? up_sel : dn_sel;
    else
      pick_dest = dn_found ? dn_sel : up_sel;
  endfunction

  function automatic logic [6:0] floor_digit(input logic [2:0] cur);
    logic [6:0] seg;
    case (cur)
      3'd0:    seg = 7'b1111001;
      3'd1:    seg = 7'b0100100;
      3'd2:    seg = 7'b0110000;
      3'd3:    seg = 7'b0011001;
      3'd4:    seg = 7'b0010010;
      3'd5:    seg = 7'b0000010;
      3'd6:    seg = 7'b1111000;
      default: seg = SEG_DASH;
    endcase
    if (int'(cur) >= NUM_FLOORS)
      seg = SEG_DASH;
    floor_digit = seg;
  endfunction

  assign sw_sync = sw_p[SYNC_STAGES-1];
  assign req     = sw_sync[NUM_FLOORS:1];

  // Stage p0..p(SYNC_STAGES-1): switch synchronizer; final stage: registered destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sw_p[s] <= '0;
      sel_p2 <= '0;
    end else begin
      sw_p[0] <= SW;
      for (int s = 1; s < SYNC_STAGES; s++)
        sw_p[s] <= sw_p[s-1];
      sel_p2 <= pick_dest(req, current, direction);
    end
  end

  assign sel  = sel_p2;
  assign HEX0 = floor_digit(current);
  assign HEX1 = SEG_F;

endmodule

// File: tb/tb_floor_destination.sv
// Directed and randomized checks of floor_destination against a cycle-level behavioural model.
module tb_floor_destination;

  localparam int NF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] SW;
  logic       direction;
  logic [2:0] current;
  logic [9:0] sw_sync;
  logic [2:0] sel;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  int checks = 0;
  int errors = 0;

  // Model history: SW values seen at the last three edges (newest first).
  logic [9:0] h0 = '0, h1 = '0, h2 = '0;
  logic [2:0] m_sel = '0;

  floor_destination #(.NUM_FLOORS(NF), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SW(SW), .direction(direction), .current(current),
    .sw_sync(sw_sync), .sel(sel), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #10 clk = ~clk;

  // Walk the shaft: first requested floor met in the preferred direction, else the other way.
  function automatic logic [2:0] model_dest(input logic [9:0] sw, input int cur, input logic dir);
    int ahead = -1;
    int behind = -1;
    if (cur >= NF) return 3'(cur);
    if (dir) begin
      for (int f = cur + 1; f < NF && ahead < 0; f++) if (sw[f+1]) ahead = f;
      for (int f = cur - 1; f >= 0 && behind < 0; f--) if (sw[f+1]) behind = f;
    end else begin
      for (int f = cur - 1; f >= 0 && ahead < 0; f--) if (sw[f+1]) ahead = f;
      for (int f = cur + 1; f < NF && behind < 0; f++) if (sw[f+1]) behind = f;
    end
    if (ahead >= 0) return 3'(ahead);
    if (behind >= 0) return 3'(behind);
    return 3'(cur);
  endfunction

  function automatic logic [6:0] model_hex0(input int cur);
    logic [6:0] tab [8];
    tab[1] = 7'b1111001; tab[2] = 7'b0100100; tab[3] = 7'b0110000; tab[4] = 7'b0011001;
    tab[5] = 7'b0010010; tab[6] = 7'b0000010; tab[7] = 7'b1111000; tab[0] = 7'b0111111;
    if (cur >= NF) return 7'b0111111;
    return tab[cur + 1];
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      h0 = '0; h1 = '0; h2 = '0; m_sel = '0;
    end else begin
      h2 = h1; h1 = h0; h0 = SW;
      m_sel = model_dest(h2, int'(current), direction);
    end
    #1;
    check("model_sel", 10'(sel), 10'(m_sel));
    check("model_sync", sw_sync, h1);
  endtask

  initial begin
    reset = 1'b1; SW = '0; direction = 1'b1; current = 3'd0;
    // 1: reset state and display
    tick();
    check("rst_sel", 10'(sel), 10'd0);
    check("rst_sync", sw_sync, 10'd0);
    reset = 1'b0; current = 3'd0; #1;
    check("hex0_floor1", 10'(HEX0), 10'(7'b1111001));
    check("hex1_F", 10'(HEX1), 10'(7'b0001110));

    // 2: synchronizer and selection latency
    SW = 10'b0000001000;
    tick();
    check("lat_sync_t1", 10'(sw_sync[3]), 10'd0);
    tick();
    check("lat_sync_t2", 10'(sw_sync[3]), 10'd1);
    check("lat_sel_t2", 10'(sel), 10'd0);
    tick();
    check("lat_sel_t3", 10'(sel), 10'd2);
    SW = '0;
    tick(); tick();
    check("drop_sel_t2", 10'(sel), 10'd2);
    tick();
    check("drop_sel_t3", 10'(sel), 10'd0);

    // 3: direction preference
    current = 3'd2; direction = 1'b1; SW = 10'b0001100100;
    tick(); tick(); tick();
    check("dir_up", 10'(sel), 10'd4);
    direction = 1'b0;
    tick();
    check("dir_down", 10'(sel), 10'd1);

    // 4: top floor going up, own-floor request ignored
    current = 3'd5; direction = 1'b1; SW = 10'b0000010000;
    tick(); tick(); tick();
    check("top_fallback", 10'(sel), 10'd3);
    SW = 10'b0001000000;
    tick(); tick(); tick();
    check("own_floor_hold", 10'(sel), 10'd5);

    // Floor 0 going down falls back upward
    current = 3'd0; direction = 1'b0; SW = 10'b0000100000;
    tick(); tick(); tick();
    check("bottom_fallback", 10'(sel), 10'd4);

    // 5: invalid current and display sweep
    current = 3'd6; SW = 10'b0001111110;
    tick();
    check("invalid_clamp", 10'(sel), 10'd6);
    check("invalid_dash", 10'(HEX0), 10'(7'b0111111));
    current = 3'd7; #1;
    check("code7_dash", 10'(HEX0), 10'(7'b0111111));
    for (int c = 0; c < NF; c++) begin
      current = 3'(c); #1;
      check("hex0_sweep", 10'(HEX0), 10'(model_hex0(c)));
    end

    // 6: reset mid-operation
    current = 3'd0; direction = 1'b1; SW = 10'b0000010000;
    tick(); tick(); tick();
    check("pre_reset_sel", 10'(sel), 10'd3);
    reset = 1'b1;
    tick();
    check("midrst_sel", 10'(sel), 10'd0);
    check("midrst_sync", sw_sync, 10'd0);
    reset = 1'b0;
    tick(); tick();
    check("resume_t2", 10'(sel), 10'd0);
    tick();
    check("resume_t3", 10'(sel), 10'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      SW        = 10'($urandom);
      current   = 3'($urandom_range(0, 7));
      direction = 1'($urandom);
      reset     = ($urandom_range(0, 39) == 0);
      tick();
      check("rand_hex0", 10'(HEX0), 10'(model_hex0(int'(current))));
      check("rand_hex1", 10'(HEX1), 10'(7'b0001110));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
